// File: rtl/out_fm_tile_scheduler.sv
`default_nettype none
// ============================================================================
// out_fm_tile_scheduler : walks output-feature-map tile bases (n,row,col) and
// sequences one tile load at a time.            Revision: 1.0
// ============================================================================
module out_fm_tile_scheduler #(
  parameter int CW = 16,
  parameter int N  = 32,
  parameter int R  = 64,
  parameter int C  = 32,
  parameter int Tn = 16,
  parameter int Tr = 64,
  parameter int Tc = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          ld_start,
  input  logic          ld_done,
  output logic          tile_valid,
  input  logic          tile_ack,
  output logic [CW-1:0] tile_base_n,
  output logic [CW-1:0] tile_base_row,
  output logic [CW-1:0] tile_base_col,
  output logic [CW-1:0] tile_idx,
  output logic          last_tile,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_WAIT_LD = 3'd2,
    S_READY   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [CW:0] c_n  = (CW+1)'(N);
  localparam logic [CW:0] c_r  = (CW+1)'(R);
  localparam logic [CW:0] c_c  = (CW+1)'(C);
  localparam logic [CW:0] c_tn = (CW+1)'(Tn);
  localparam logic [CW:0] c_tr = (CW+1)'(Tr);
  localparam logic [CW:0] c_tc = (CW+1)'(Tc);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_base_n, r_base_row, r_base_col, r_idx;
  logic [CW-1:0] w_base_n_nxt, w_base_row_nxt, w_base_col_nxt, w_idx_nxt;

  // Sums carry one extra bit so a base near the top of the range cannot wrap.
  logic [CW:0] w_sum_n, w_sum_row, w_sum_col;
  logic        w_n_end, w_row_end, w_col_end;

  assign w_sum_n   = {1'b0, r_base_n}   + c_tn;
  assign w_sum_row = {1'b0, r_base_row} + c_tr;
  assign w_sum_col = {1'b0, r_base_col} + c_tc;
  assign w_n_end   = (w_sum_n   >= c_n);
  assign w_row_end = (w_sum_row >= c_r);
  assign w_col_end = (w_sum_col >= c_c);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_base_n   <= '0;
      r_base_row <= '0;
      r_base_col <= '0;
      r_idx      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_base_n   <= w_base_n_nxt;
      r_base_row <= w_base_row_nxt;
      r_base_col <= w_base_col_nxt;
      r_idx      <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_base_n_nxt   = r_base_n;
    w_base_row_nxt = r_base_row;
    w_base_col_nxt = r_base_col;
    w_idx_nxt      = r_idx;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_base_n_nxt   = '0;
          w_base_row_nxt = '0;
          w_base_col_nxt = '0;
          w_idx_nxt      = '0;
          w_state_nxt    = S_LOAD;
        end
      end
      S_LOAD:    w_state_nxt = S_WAIT_LD;
      S_WAIT_LD: if (ld_done) w_state_nxt = S_READY;
      S_READY: begin
        if (tile_ack) begin
          if (last_tile) begin
            w_state_nxt = S_DONE;
          end else begin
            // Column fastest, then row, then channel.
            w_base_col_nxt = w_col_end ? '0 : w_sum_col[CW-1:0];
            if (w_col_end) begin
              w_base_row_nxt = w_row_end ? '0 : w_sum_row[CW-1:0];
              if (w_row_end) w_base_n_nxt = w_sum_n[CW-1:0];
            end
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // Abort wins over everything but leaves the bases and index untouched.
    if (abort) begin
      w_state_nxt    = S_IDLE;
      w_base_n_nxt   = r_base_n;
      w_base_row_nxt = r_base_row;
      w_base_col_nxt = r_base_col;
      w_idx_nxt      = r_idx;
    end
  end

  always_comb begin
    ld_start   = (r_state == S_LOAD);
    tile_valid = (r_state == S_READY);
    done       = (r_state == S_DONE);
    busy       = (r_state != S_IDLE);
    last_tile  = w_col_end && w_row_end && w_n_end;
  end

  assign tile_base_n   = r_base_n;
  assign tile_base_row = r_base_row;
  assign tile_base_col = r_base_col;
  assign tile_idx      = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_out_fm_tile_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_out_fm_tile_scheduler : directed stimulus with a tile-list model checked
// every cycle on two parameterisations.          Revision: 1.0
// ============================================================================
module tb_out_fm_tile_scheduler;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic a_start = 0, a_abort = 0, a_ld_done = 0, a_ack = 0;
  logic a_ld_start, a_valid, a_last, a_busy, a_done;
  logic [CW-1:0] a_bn, a_br, a_bc, a_idx;
  logic b_start = 0, b_abort = 0, b_ld_done = 0, b_ack = 0;
  logic b_ld_start, b_valid, b_last, b_busy, b_done;
  logic [CW-1:0] b_bn, b_br, b_bc, b_idx;

  out_fm_tile_scheduler #(.CW(CW)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
    .ld_start(a_ld_start), .ld_done(a_ld_done), .tile_valid(a_valid),
    .tile_ack(a_ack), .tile_base_n(a_bn), .tile_base_row(a_br),
    .tile_base_col(a_bc), .tile_idx(a_idx), .last_tile(a_last),
    .busy(a_busy), .done(a_done));

  out_fm_tile_scheduler #(.CW(CW), .N(16), .R(20), .C(40), .Tn(16), .Tr(16), .Tc(16)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
    .ld_start(b_ld_start), .ld_done(b_ld_done), .tile_valid(b_valid),
    .tile_ack(b_ack), .tile_base_n(b_bn), .tile_base_row(b_br),
    .tile_base_col(b_bc), .tile_idx(b_idx), .last_tile(b_last),
    .busy(b_busy), .done(b_done));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: tile list + protocol phase ----------------
  int tl_n[2][0:63], tl_r[2][0:63], tl_c[2][0:63];
  int cnt[2];
  int m_ph[2];   // 0 idle, 1 load, 2 wait, 3 ready, 4 done
  int m_k[2], m_cn[2], m_cr[2], m_cc[2];

  task automatic build(input int i, input int nn, input int rr, input int cc,
                       input int tn, input int tr, input int tc);
    cnt[i] = 0;
    for (int n = 0; n < nn; n += tn)
      for (int r = 0; r < rr; r += tr)
        for (int c = 0; c < cc; c += tc) begin
          tl_n[i][cnt[i]] = n; tl_r[i][cnt[i]] = r; tl_c[i][cnt[i]] = c;
          cnt[i]++;
        end
  endtask

  task automatic load_cur(input int i);
    m_cn[i] = tl_n[i][m_k[i]]; m_cr[i] = tl_r[i][m_k[i]]; m_cc[i] = tl_c[i][m_k[i]];
  endtask

  task automatic step(input int i, input logic st, input logic ab, input logic ld, input logic ak);
    if (ab) m_ph[i] = 0;
    else case (m_ph[i])
      0: if (st) begin m_k[i] = 0; load_cur(i); m_ph[i] = 1; end
      1: m_ph[i] = 2;
      2: if (ld) m_ph[i] = 3;
      3: if (ak) begin
           if (m_k[i] == cnt[i] - 1) m_ph[i] = 4;
           else begin m_k[i]++; load_cur(i); m_ph[i] = 1; end
         end
      default: m_ph[i] = 0;
    endcase
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_ph[i] = 0; m_k[i] = 0; m_cn[i] = 0; m_cr[i] = 0; m_cc[i] = 0;
      end
    end else begin
      step(0, a_start, a_abort, a_ld_done, a_ack);
      step(1, b_start, b_abort, b_ld_done, b_ack);
    end
  end

  task automatic check_inst(input int i, input logic lds, input logic vld, input logic lst,
                            input logic bsy, input logic dn, input int bn, input int br,
                            input int bc, input int idx);
    string p;
    int    l;
    p = (i == 0) ? "A" : "B";
    l = cnt[i] - 1;
    chk({p, ".ld_start"},   lds, m_ph[i] == 1);
    chk({p, ".tile_valid"}, vld, m_ph[i] == 3);
    chk({p, ".done"},       dn,  m_ph[i] == 4);
    chk({p, ".busy"},       bsy, m_ph[i] != 0);
    chk({p, ".base_n"},     bn,  m_cn[i]);
    chk({p, ".base_row"},   br,  m_cr[i]);
    chk({p, ".base_col"},   bc,  m_cc[i]);
    chk({p, ".tile_idx"},   idx, m_k[i]);
    chk({p, ".last_tile"},  lst, (m_cn[i] == tl_n[i][l]) && (m_cr[i] == tl_r[i][l]) &&
                                 (m_cc[i] == tl_c[i][l]));
  endtask

  int a_qn[$], a_qr[$], a_qc[$], a_qi[$], a_ql[$];
  int b_qr[$], b_qc[$];
  int a_dones = 0, b_dones = 0;

  always @(negedge clk) begin
    check_inst(0, a_ld_start, a_valid, a_last, a_busy, a_done, a_bn, a_br, a_bc, a_idx);
    check_inst(1, b_ld_start, b_valid, b_last, b_busy, b_done, b_bn, b_br, b_bc, b_idx);
    if (a_ld_start) begin
      a_qn.push_back(a_bn); a_qr.push_back(a_br); a_qc.push_back(a_bc);
      a_qi.push_back(a_idx); a_ql.push_back(a_last);
    end
    if (b_ld_start) begin b_qr.push_back(b_br); b_qc.push_back(b_bc); end
    if (a_done) a_dones++;
    if (b_done) b_dones++;
  end

  // ---------------- stimulus helpers ----------------
  // which: 0 start, 1 abort, 2 ld_done, 3 tile_ack
  task automatic set_in(input int i, input int which, input logic v);
    if (i == 0) case (which)
      0: a_start = v; 1: a_abort = v; 2: a_ld_done = v; default: a_ack = v;
    endcase else case (which)
      0: b_start = v; 1: b_abort = v; 2: b_ld_done = v; default: b_ack = v;
    endcase
  endtask

  task automatic pulse(input int i, input int which);
    set_in(i, which, 1'b1);
    @(negedge clk);
    set_in(i, which, 1'b0);
  endtask

  // which: 0 ld_start, 1 tile_valid, 2 done
  function automatic logic get_out(input int i, input int which);
    if (i == 0) return (which == 0) ? a_ld_start : (which == 1) ? a_valid : a_done;
    return (which == 0) ? b_ld_start : (which == 1) ? b_valid : b_done;
  endfunction

  task automatic wait_out(input int i, input int which);
    for (int t = 0; t < 100; t++) begin
      if (get_out(i, which)) return;
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL timeout inst %0d output %0d: got 0 expected 1", i, which);
  endtask

  task automatic serve_tile(input int i, input int ldd, input int ackd);
    wait_out(i, 0);
    repeat (ldd) @(negedge clk);
    pulse(i, 2);
    wait_out(i, 1);
    repeat (ackd) @(negedge clk);
    pulse(i, 3);
  endtask

  int en[4] = '{0, 0, 16, 16};
  int ec[4] = '{0, 16, 0, 16};
  int bc_exp[6] = '{0, 16, 32, 0, 16, 32};
  int br_exp[6] = '{0, 0, 0, 16, 16, 16};
  int sv_n, sv_r, sv_c, d0;

  initial begin
    build(0, 32, 64, 32, 16, 64, 16);
    build(1, 16, 20, 40, 16, 16, 16);
    chk("model.cnt_a", cnt[0], 4);
    chk("model.cnt_b", cnt[1], 6);
    repeat (3) @(negedge clk);
    chk("reset.busy", a_busy, 0);
    chk("reset.last", a_last, 0);
    rst = 1'b1;
    @(negedge clk);

    // Default layer: 4 tiles, ld_done 2 cycles after ld_start, immediate ack.
    a_qn.delete(); a_qr.delete(); a_qc.delete(); a_qi.delete(); a_ql.delete();
    d0 = a_dones;
    pulse(0, 0);
    repeat (4) serve_tile(0, 2, 0);
    wait_out(0, 2);
    @(negedge clk);
    chk("A.ld_start_count", a_qn.size(), 4);
    chk("A.done_count", a_dones - d0, 1);
    if (a_qn.size() == 4)
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("A.seq%0d.n", k), a_qn[k], en[k]);
        chk($sformatf("A.seq%0d.row", k), a_qr[k], 0);
        chk($sformatf("A.seq%0d.col", k), a_qc[k], ec[k]);
        chk($sformatf("A.seq%0d.idx", k), a_qi[k], k);
        chk($sformatf("A.seq%0d.last", k), a_ql[k], (k == 3) ? 1 : 0);
      end

    // Non-divisible layer on B.
    b_qr.delete(); b_qc.delete();
    pulse(1, 0);
    repeat (6) serve_tile(1, 1, 0);
    wait_out(1, 2);
    @(negedge clk);
    chk("B.ld_start_count", b_qc.size(), 6);
    chk("B.done_count", b_dones, 1);
    if (b_qc.size() == 6)
      for (int k = 0; k < 6; k++) begin
        chk($sformatf("B.seq%0d.col", k), b_qc[k], bc_exp[k]);
        chk($sformatf("B.seq%0d.row", k), b_qr[k], br_exp[k]);
      end

    // Stray handshakes and slow consumer.
    pulse(0, 0);
    wait_out(0, 0);
    @(negedge clk);
    a_ack = 1; a_start = 1;
    @(negedge clk);
    a_ack = 0; a_start = 0;
    chk("stray.wait_valid", a_valid, 0);
    chk("stray.wait_idx", a_idx, 0);
    pulse(0, 2);
    wait_out(0, 1);
    a_ld_done = 1; a_start = 1;
    @(negedge clk);
    a_ld_done = 0; a_start = 0;
    sv_n = a_bn; sv_r = a_br; sv_c = a_bc;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      chk("slow.valid", a_valid, 1);
      chk("slow.col", a_bc, sv_c);
      chk("slow.row", a_br, sv_r);
      chk("slow.n", a_bn, sv_n);
    end
    pulse(0, 3);
    repeat (3) serve_tile(0, 1, 0);
    wait_out(0, 2);
    @(negedge clk);

    // Abort in WAIT_LD of tile 2.
    d0 = a_dones;
    pulse(0, 0);
    serve_tile(0, 1, 0);
    serve_tile(0, 1, 0);
    wait_out(0, 0);
    @(negedge clk);
    pulse(0, 1);
    chk("abort.busy", a_busy, 0);
    chk("abort.idx_hold", a_idx, 2);
    repeat (3) @(negedge clk);
    chk("abort.no_done", a_dones - d0, 0);
    pulse(0, 0);
    chk("restart.ld_start", a_ld_start, 1);
    chk("restart.idx", a_idx, 0);
    chk("restart.col", a_bc, 0);
    chk("restart.n", a_bn, 0);
    repeat (4) serve_tile(0, 1, 0);
    wait_out(0, 2);
    @(negedge clk);

    // Asynchronous reset mid-cycle while READY.
    pulse(0, 0);
    wait_out(0, 0);
    @(negedge clk);
    pulse(0, 2);
    wait_out(0, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst.valid", a_valid, 0);
    chk("arst.busy", a_busy, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst.idle_busy", a_busy, 0);
    chk("arst.base_col", a_bc, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/out_fm_tile_scheduler.md
# out_fm_tile_scheduler

Sequences the output-feature-map tile loads for one convolution layer. It walks the tile bases (n, row, col) over the full N×R×C output volume in steps of Tn/Tr/Tc and starts one tile load at a time. It holds the bases stable for the load/filter path during each load, then offers the loaded tile to the compute side. It sits between the layer controller and the out_fm load path (loader plus load filter), which consume `tile_base_n/row/col`.

## Interface
Parameters:
- CW, 16, width of tile base and index counters
- N, 32, output channels total
- R, 64, output rows total
- C, 32, output columns total
- Tn, 16, channel tile size
- Tr, 64, row tile size
- Tc, 16, column tile size

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a layer; honored only in IDLE
- abort  in  1  synchronous; forces IDLE next cycle from any state, no `done` pulse
- ld_start  out  1  one-cycle pulse: begin loading current tile
- ld_done  in  1  load path finished current tile; honored only in WAIT_LD
- tile_valid  out  1  current tile loaded and available to compute
- tile_ack  in  1  compute finished with current tile; honored only when tile_valid=1
- tile_base_n  out  CW  current channel base
- tile_base_row  out  CW  current row base
- tile_base_col  out  CW  current column base
- tile_idx  out  CW  ordinal of current tile, 0-based
- last_tile  out  1  current tile is the final tile of the layer
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the last tile is acknowledged

## Operation
- FSM states: IDLE, LOAD, WAIT_LD, READY, DONE.
- IDLE:
  - On start: bases=0, tile_idx=0, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD: `ld_start`=1 for exactly this one cycle, then go to WAIT_LD.
- WAIT_LD: on ld_done, go to READY. ld_done seen in any other state is ignored.
- READY: tile_valid=1.
  - On tile_ack with last_tile=0: advance bases, tile_idx+1, go to LOAD.
  - On tile_ack with last_tile=1: go to DONE.
- DONE: done=1 for one cycle, then go to IDLE. Bases keep the last tile's values until the next start.
- Traversal order: col innermost, then row, then n. This matches the column-fastest element order of the load filter.
- Advance rule, column: if base_col+Tc >= C, then col=0 and carry to row; else col=base_col+Tc.
- Advance rule, row: the same as column using Tr/R, carrying into n.
- Advance rule, n: base_n+Tn. It never wraps, because last_tile prevents advancing past the final tile.
- last_tile = (base_col+Tc>=C) && (base_row+Tr>=R) && (base_n+Tn>=N), evaluated combinationally from the registered bases.
- Arithmetic: sums are computed at CW+1 bits to avoid overflow. Partial edge tiles (e.g. C not a multiple of Tc) are issued with their base. Zero-fill of the out-of-range elements is done by the filter, not here.
- Priority: abort > all other inputs. start while busy is ignored. tile_ack and ld_done outside their honored states are ignored.
- Reset values (rst=0):
  - state=IDLE.
  - All outputs 0: ld_start, tile_valid, done, busy, last_tile, bases, tile_idx.

## Timing
- start at cycle t: busy=1 and ld_start=1 at t+1; new bases are valid at t+1 and stable until the next advance.
- ld_done at cycle u (state WAIT_LD): tile_valid=1 at u+1.
- tile_ack at cycle v (READY, not last): tile_valid=0, updated bases and ld_start=1 at v+1.
- tile_ack at cycle v (last tile): done=1 at v+1, busy=0 and state IDLE at v+2.
- Minimum per-tile overhead: 3 cycles (LOAD, WAIT_LD, READY), with ld_done and tile_ack asserted as early as allowed.
- Bases never change while the state is WAIT_LD or READY.
- rst asserted mid-operation: all state and outputs clear immediately, with no clock needed.
- abort at cycle a: IDLE at a+1, all pulse outputs 0; the bases hold their value.

## Test plan
- Default parameters (4 tiles): start, ld_done 2 cycles after each ld_start, immediate tile_ack -> (n,row,col) sequence (0,0,0),(0,0,16),(16,0,0),(16,0,16); tile_idx 0..3; last_tile only on tile 3; exactly 4 ld_start pulses, then one done pulse.
- Non-divisible sizes (C=40, R=20, Tr=16, N=16, Tn=16): 6 tiles; col bases 0,16,32 within each row; row bases 0 then 16.
- Stray handshakes: ld_done pulsed during READY and tile_ack pulsed during WAIT_LD -> no state change, no tile advance; start asserted while busy is ignored.
- Slow consumer: tile_ack held off 20 cycles -> tile_valid stays 1 and the bases stay constant for all 20 cycles.
- abort asserted in WAIT_LD of tile 2 -> IDLE next cycle; no done pulse; a following start restarts at (0,0,0) with tile_idx 0.
- Asynchronous reset asserted between clock edges during READY -> tile_valid and busy drop to 0 before the next edge; after release, IDLE with all outputs 0.
